booth_seq_mul_ctrl: RTL and testbench



---
 rtl/booth_seq_mul_ctrl_pkg.sv | 14 +
 rtl/booth_seq_mul_ctrl_if.sv | 12 +
 rtl/booth_seq_mul_ctrl_cla.sv | 19 +
 rtl/booth_seq_mul_ctrl_pp_sel.sv | 17 +
 rtl/booth_seq_mul_ctrl.sv | 72 +++++++
 tb/tb_booth_seq_mul_ctrl.sv | 150 +++++++++++++++
 6 files changed

// File: rtl/booth_seq_mul_ctrl_pkg.sv
// booth_seq_mul_ctrl_pkg: shared states, Booth op encoding and sizing for the radix-4 multiplier
package booth_pkg;
  localparam int XLEN = 32;
  localparam int PLEN = 64;
  localparam int NITER = 17;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_op_t;
  function automatic booth_op_t booth_dec(input logic [2:0] t);
    return (t == 3'b001 || t == 3'b010) ? POS1 :
           (t == 3'b011) ? POS2 :
           (t == 3'b100) ? NEG2 :
           (t == 3'b101 || t == 3'b110) ? NEG1 : ZERO;
  endfunction
endpackage

// File: rtl/booth_seq_mul_ctrl_if.sv
// booth_seq_mul_ctrl_if: operand/product handshake bundle between issue stage and multiplier
interface booth_seq_mul_ctrl_if;
  import booth_pkg::*;
  logic in_valid, in_ready, in_a_signed, in_b_signed, flush;
  logic [XLEN-1:0] in_a, in_b;
  logic out_valid, out_ready, busy;
  logic [PLEN-1:0] out_prod;
  modport master (output in_valid, in_a, in_b, in_a_signed, in_b_signed, flush, out_ready,
                  input in_ready, out_valid, out_prod, busy);
  modport slave (input in_valid, in_a, in_b, in_a_signed, in_b_signed, flush, out_ready,
                 output in_ready, out_valid, out_prod, busy);
endinterface

// File: rtl/booth_seq_mul_ctrl_cla.sv
// CLA_64bits: 64-bit carry-select adder built from four 16-bit blocks
module CLA_64bits (
  input  logic [63:0] in1,
  input  logic [63:0] in2,
  input  logic        cin,
  output logic [63:0] res
);
  logic [3:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < 4; i++) begin : g_blk
    logic [16:0] s0, s1;
    assign s0 = {1'b0, in1[16*i +: 16]} + {1'b0, in2[16*i +: 16]};
    assign s1 = s0 + 17'd1;
    assign res[16*i +: 16] = c[i] ? s1[15:0] : s0[15:0];
    if (i < 3) begin : g_c
      assign c[i+1] = c[i] ? s1[16] : s0[16];
    end
  end
endmodule

// File: rtl/booth_seq_mul_ctrl_pp_sel.sv
// booth_r4_pp_sel: radix-4 Booth triplet decode into partial product and negate flag
module booth_r4_pp_sel
  import booth_pkg::*;
(
  input  logic [2:0]      trip,
  input  logic [PLEN-1:0] mcand,
  output logic [PLEN-1:0] pp,
  output logic            neg
);
  booth_op_t op;
  always_comb begin
    op = booth_dec(trip);
    pp = (op == POS1 || op == NEG1) ? mcand :
         (op == POS2 || op == NEG2) ? {mcand[PLEN-2:0], 1'b0} : '0;
    neg = (op == NEG1 || op == NEG2);
  end
endmodule

// File: rtl/booth_seq_mul_ctrl.sv
// booth_seq_mul_ctrl: sequential radix-4 Booth 32x32->64 multiplier sharing one 64-bit adder
// Define EARLY_TERM_EN to exit CALC as soon as all remaining multiplier triplets are null.
module booth_seq_mul_ctrl
  import booth_pkg::*;
(
  input logic clk,
  input logic rst_n,
  booth_seq_mul_ctrl_if.slave bus
);
  state_t state, state_nx;
  logic [PLEN-1:0] acc, mcand, pp, sum;
  logic [XLEN+2:0] mplr, mplr_sh;
  logic [4:0] cnt;
  logic neg, acc_we, accept, last;
  assign accept = bus.in_valid && bus.in_ready;
  assign mplr_sh = {mplr[XLEN+2], mplr[XLEN+2], mplr[XLEN+2:2]};
  assign last = cnt == 5'(NITER - 1);
  assign bus.in_ready = state == IDLE && !bus.flush;
  assign bus.out_valid = state == DONE;
  assign bus.out_prod = acc;
  assign bus.busy = state != IDLE;
  booth_r4_pp_sel u_pp (.trip(mplr[2:0]), .mcand(mcand), .pp(pp), .neg(neg));
  CLA_64bits u_add (.in1(acc), .in2(neg ? ~pp : pp), .cin(neg), .res(sum));
`ifdef EARLY_TERM_EN
  logic null_now, null_nx;
  assign null_now = &mplr || ~|mplr;
  assign null_nx = &mplr_sh || ~|mplr_sh;
`endif
  always_comb begin
    state_nx = state;
    acc_we = 1'b0;
    case (state)
      IDLE: state_nx = accept ? CALC : IDLE;
      CALC: begin
`ifdef EARLY_TERM_EN
        // A null multiplier now skips the add; a null one after this shift ends with the add done.
        acc_we = !null_now;
        state_nx = (null_now || null_nx || last) ? DONE : CALC;
`else
        acc_we = 1'b1;
        state_nx = last ? DONE : CALC;
`endif
      end
      DONE: state_nx = bus.out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
    if (bus.flush) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      mcand <= '0;
      mplr <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      if (bus.flush) acc <= '0;
      else if (accept) begin
        acc <= '0;
        cnt <= '0;
        mcand <= {{XLEN{bus.in_a[XLEN-1] & bus.in_a_signed}}, bus.in_a};
        mplr <= {{2{bus.in_b[XLEN-1] & bus.in_b_signed}}, bus.in_b, 1'b0};
      end else if (state == CALC) begin
        if (acc_we) acc <= sum;
        mcand <= mcand << 2;
        mplr <= mplr_sh;
        cnt <= cnt + 5'd1;
      end
    end
  end
endmodule

// File: tb/tb_booth_seq_mul_ctrl.sv
// tb_booth_seq_mul_ctrl: scoreboard bench with directed, hand-computed Booth products
module tb_booth_seq_mul_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  booth_seq_mul_ctrl_if bus();
  booth_seq_mul_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
`ifdef EARLY_TERM_EN
  localparam int LAT = 0;
  localparam int LAT_B0 = 1;
  localparam int LAT_B3 = 2;
`else
  localparam int LAT = 17;
  localparam int LAT_B0 = 17;
  localparam int LAT_B3 = 17;
`endif
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected product: got %h want none", bus.out_prod);
      end else chk("product", bus.out_prod, exp_q.pop_front());
    end
  end
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic as, input logic bs,
                       input logic [63:0] exp, input logic push);
    int t = 0;
    while (!bus.in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus.in_ready) chk("in_ready timeout", 64'(bus.in_ready), 64'd1);
    bus.in_a = a;
    bus.in_b = b;
    bus.in_a_signed = as;
    bus.in_b_signed = bs;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (push) exp_q.push_back(exp);
  endtask
  task automatic await(input string name, input int lat);
    int cyc = 0;
    while (!bus.out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!bus.out_valid) chk({name, " timeout"}, 64'(bus.out_valid), 64'd1);
    else if (lat != 0) chk({name, " latency"}, 64'(cyc), 64'(lat));
  endtask
  task automatic op(input string name, input logic [31:0] a, input logic [31:0] b, input logic as,
                    input logic bs, input logic [63:0] exp, input int lat);
    issue(a, b, as, bs, exp, 1'b1);
    await(name, lat);
    @(posedge clk); #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic seen;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_a_signed = 1'b0;
    bus.in_b_signed = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    chk("rst in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst busy", 64'(bus.busy), 64'd0);
    chk("rst out_prod", bus.out_prod, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    op("s -3*7", 32'hFFFF_FFFD, 32'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, LAT);
    op("u max*max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001, LAT);
    op("mixed -1*2", 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, LAT);
    op("s min*min", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000, LAT);
    op("s max*min", 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 64'hC000_0000_8000_0000, LAT);
    bus.out_ready = 1'b0;
    issue(32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 64'h1_0000_0000, 1'b1);
    await("stall", LAT);
    for (int i = 0; i < 5; i++) begin
      chk("stall out_prod", bus.out_prod, 64'h1_0000_0000);
      chk("stall in_ready", 64'(bus.in_ready), 64'd0);
      chk("stall busy", 64'(bus.busy), 64'd1);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post-handshake in_ready", 64'(bus.in_ready), 64'd1);
    chk("post-handshake out_valid", 64'(bus.out_valid), 64'd0);
    issue(32'd5, 32'd6, 1'b0, 1'b0, 64'd0, 1'b0);
    repeat (8) begin
      @(posedge clk); #1;
    end
    bus.flush = 1'b1;
    #1;
    chk("flush in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush busy", 64'(bus.busy), 64'd0);
    chk("flush out_prod", bus.out_prod, 64'd0);
    seen = 1'b0;
    repeat (20) begin
      seen |= bus.out_valid;
      @(posedge clk); #1;
    end
    chk("flush no out_valid", 64'(seen), 64'd0);
    op("5*6", 32'd5, 32'd6, 1'b0, 1'b0, 64'h1E, LAT);
    issue(32'd7, 32'd9, 1'b0, 1'b0, 64'd0, 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst busy", 64'(bus.busy), 64'd0);
    chk("async rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("async rst in_ready", 64'(bus.in_ready), 64'd1);
    chk("async rst out_prod", bus.out_prod, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    op("s x*-1", 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'hFFFF_FFFF_EDCB_A988, LAT);
    op("1234*0", 32'd1234, 32'd0, 1'b0, 1'b0, 64'd0, LAT_B0);
    op("1234*3", 32'd1234, 32'd3, 1'b0, 1'b0, 64'd3702, LAT_B3);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("queue drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
